// File: rtl/link_pkg.sv
// Shared link constants and deframer state encoding, common to the transmit framer.
package link_pkg;

  typedef enum logic [1:0] {HUNT, SYNC, DATA, PAR} state_t;

  localparam int unsigned LINK_SYNC_W       = 4;
  localparam logic [3:0]  LINK_SYNC_PATTERN = 4'b1110;
  localparam int unsigned LINK_DATA_W       = 4;

endpackage

// File: rtl/link_sync_detect.sv
// Sync-word window: the last SYNC_W received bits (including the one sampled this edge)
// compared against SYNC_PATTERN; the deframer decides when the match is meaningful.
module link_sync_detect
  import link_pkg::*;
#(
  parameter int unsigned         SYNC_W       = LINK_SYNC_W,
  parameter logic [SYNC_W-1:0]   SYNC_PATTERN = LINK_SYNC_PATTERN
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit,
  output logic o_match
);

  // Only the older SYNC_W-1 bits are stored; the newest bit comes straight from i_bit.
  logic [SYNC_W-2:0] r_win;
  logic [SYNC_W-1:0] w_next;

  assign w_next  = {r_win, i_bit};
  assign o_match = (w_next == SYNC_PATTERN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_win <= '0;
    else          r_win <= w_next[SYNC_W-2:0];
  end

endmodule

// File: rtl/link_rx_deframer.sv
// Receive deframer: hunts for the sync word, extracts payload + even parity, tracks lock.
// Optional saturating error counter enabled by defining DEFRAMER_ERRCNT_EN.
module link_rx_deframer
  import link_pkg::*;
#(
  parameter int unsigned       SYNC_W       = LINK_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = LINK_SYNC_PATTERN,
  parameter int unsigned       DATA_W       = LINK_DATA_W,
  parameter int unsigned       LOCK_FRAMES  = 2,
  parameter int unsigned       LOSS_FRAMES  = 2
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              datain,
  output logic [0:DATA_W-1] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              sync_err,
  output logic              locked,
  output logic [3:0]        err_count
);

  localparam int unsigned CNT_MAX = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t            r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic [0:DATA_W-1] r_stage, w_stage_n;
  logic [0:DATA_W-1] r_data, w_data_n;
  logic              r_par, w_par_n;
  logic              r_valid, w_valid_n;
  logic              r_perr, w_perr_n;
  logic              r_serr, w_serr_n;
  logic              r_locked, w_locked_n;
  logic [2:0]        r_good, w_good_n;
  logic [2:0]        r_bad, w_bad_n;
  logic              w_match;

  link_sync_detect #(
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync_detect (
    .i_clk   (clkin),
    .i_rst_n (rstn),
    .i_bit   (datain),
    .o_match (w_match)
  );

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state  <= HUNT;
      r_cnt    <= '0;
      r_stage  <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_serr   <= 1'b0;
      r_locked <= 1'b0;
      r_good   <= '0;
      r_bad    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_stage  <= w_stage_n;
      r_data   <= w_data_n;
      r_par    <= w_par_n;
      r_valid  <= w_valid_n;
      r_perr   <= w_perr_n;
      r_serr   <= w_serr_n;
      r_locked <= w_locked_n;
      r_good   <= w_good_n;
      r_bad    <= w_bad_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_stage_n  = r_stage;
    w_data_n   = r_data;
    w_par_n    = r_par;
    w_valid_n  = 1'b0;
    w_perr_n   = 1'b0;
    w_serr_n   = 1'b0;
    w_locked_n = r_locked;
    w_good_n   = r_good;
    w_bad_n    = r_bad;
    unique case (r_state)
      HUNT: begin
        if (w_match) begin
          w_state_n = DATA;
          w_cnt_n   = '0;
          w_par_n   = 1'b0;
          w_bad_n   = '0;
        end
      end
      DATA: begin
        // Shift toward index 0 so the first payload bit ends up in data_out[0].
        w_stage_n = {r_stage[1:DATA_W-1], datain};
        w_par_n   = r_par ^ datain;
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_state_n = PAR;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      PAR: begin
        w_state_n = SYNC;
        w_cnt_n   = '0;
        if ((r_par ^ datain) == 1'b0) begin
          w_data_n  = r_stage;
          w_valid_n = 1'b1;
          if (r_good != 3'd7) w_good_n = r_good + 3'd1;
          if (w_good_n == 3'(LOCK_FRAMES)) w_locked_n = 1'b1;
        end else begin
          w_perr_n = 1'b1;
          w_good_n = '0;
        end
      end
      SYNC: begin
        if (r_cnt == CNT_W'(SYNC_W - 1)) begin
          w_cnt_n = '0;
          w_par_n = 1'b0;
          if (w_match) begin
            w_bad_n   = '0;
            w_state_n = DATA;
          end else begin
            w_serr_n = 1'b1;
            w_good_n = '0;
            if (r_bad != 3'd7) w_bad_n = r_bad + 3'd1;
            if (w_bad_n >= 3'(LOSS_FRAMES)) begin
              w_state_n  = HUNT;
              w_locked_n = 1'b0;
            end else begin
              w_state_n = DATA;
            end
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = HUNT;
    endcase
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign sync_err   = r_serr;
  assign locked     = r_locked;

`ifdef DEFRAMER_ERRCNT_EN
  logic [3:0] r_err;

  // Counts on the same edge the error pulse is registered.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn)                                       r_err <= '0;
    else if ((w_perr_n || w_serr_n) && r_err != 4'hF) r_err <= r_err + 4'd1;
  end

  assign err_count = r_err;
`else
  assign err_count = 4'h0;
`endif

endmodule
